// File: rtl/pc_sequencer_if.sv
// Control bundle between the PC sequencer and the datapath it drives.
// The sequencer uses the master modport; the datapath (or a bench) uses slave.
interface pc_sequencer_if;
    logic        imem_ready;
    logic        dmem_ready;
    logic [2:0]  opclass;
    logic        take_branch;
    logic        stall_req;
    logic        imem_req;
    logic        ir_write;
    logic        dmem_req;
    logic        dmem_we;
    logic        reg_write;
    logic        link_write;
    logic        pc_write;
    logic [1:0]  pc_sel;
    logic        halted;
    logic [2:0]  state;
    logic [31:0] instr_count;

    modport master (
        input  imem_ready, dmem_ready, opclass, take_branch, stall_req,
        output imem_req, ir_write, dmem_req, dmem_we, reg_write, link_write,
               pc_write, pc_sel, halted, state, instr_count
    );

    modport slave (
        output imem_ready, dmem_ready, opclass, take_branch, stall_req,
        input  imem_req, ir_write, dmem_req, dmem_we, reg_write, link_write,
               pc_write, pc_sel, halted, state, instr_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle control FSM around the program counter: fetch, decode, execute,
// memory and write-back sequencing, PC source selection and retire counting.
module pc_sequencer (
    input  logic            clk,
    input  logic            reset,
    pc_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        OP_ALU    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_STORE  = 3'd2,
        OP_BRANCH = 3'd3,
        OP_JUMP   = 3'd4,
        OP_CALL   = 3'd5,
        OP_RET    = 3'd6,
        OP_HALT   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_LINK   = 2'd3
    } pc_sel_e;

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [31:0] instr_count_q, instr_count_d;
    logic        retire;

    logic        imem_req, ir_write, dmem_req, dmem_we;
    logic        reg_write, link_write, pc_write, halted;
    pc_sel_e     pc_sel;

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            op_q          <= OP_ALU;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            instr_count_q <= instr_count_d;
        end
    end

    // NOTE: every signal written below gets a default first, so no path
    // through the case statements can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        retire     = 1'b0;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_write  = 1'b0;
        link_write = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = PC_PLUS4;
        halted     = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = bus.imem_ready;
                if (bus.imem_ready) state_d = S_DECODE;
            end

            S_DECODE: begin
                op_d = op_e'(bus.opclass);
                if (!bus.stall_req) state_d = S_EXEC;
            end

            S_EXEC: begin
                case (op_q)
                    OP_ALU:             state_d = S_WB;
                    OP_LOAD, OP_STORE:  state_d = S_MEM;
                    OP_BRANCH: begin
                        pc_write = 1'b1;
                        pc_sel   = bus.take_branch ? PC_BRANCH : PC_PLUS4;
                        state_d  = S_FETCH;
                        retire   = 1'b1;
                    end
                    OP_JUMP: begin
                        pc_write = 1'b1;
                        pc_sel   = PC_JUMP;
                        state_d  = S_FETCH;
                        retire   = 1'b1;
                    end
                    OP_CALL: begin
                        pc_write   = 1'b1;
                        pc_sel     = PC_JUMP;
                        link_write = 1'b1;
                        state_d    = S_FETCH;
                        retire     = 1'b1;
                    end
                    OP_RET: begin
                        pc_write = 1'b1;
                        pc_sel   = PC_LINK;
                        state_d  = S_FETCH;
                        retire   = 1'b1;
                    end
                    default: begin
                        state_d = S_HALT;
                        retire  = 1'b1;
                    end
                endcase
            end

            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op_q == OP_STORE);
                if (bus.dmem_ready) begin
                    if (op_q == OP_STORE) begin
                        // Stores retire straight out of MEM; the PC advances here.
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                        retire   = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end

            S_HALT: halted = 1'b1;

            default: state_d = S_IDLE;
        endcase

        instr_count_d = instr_count_q + 32'(retire);
    end

    assign bus.imem_req    = imem_req;
    assign bus.ir_write    = ir_write;
    assign bus.dmem_req    = dmem_req;
    assign bus.dmem_we     = dmem_we;
    assign bus.reg_write   = reg_write;
    assign bus.link_write  = link_write;
    assign bus.pc_write    = pc_write;
    assign bus.pc_sel      = pc_sel;
    assign bus.halted      = halted;
    assign bus.state       = state_q;
    assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: each instruction is expanded into its
// expected per-cycle control pattern and compared cycle by cycle.
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic reset;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] state;
        logic       imem_req;
        logic       ir_write;
        logic       dmem_req;
        logic       dmem_we;
        logic       reg_write;
        logic       link_write;
        logic       pc_write;
        logic [1:0] pc_sel;
        logic       halted;
    } outs_t;

    int          errors = 0;
    int          checks = 0;
    int unsigned model_count = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [12:0] observed();
        return {bus.state, bus.imem_req, bus.ir_write, bus.dmem_req, bus.dmem_we,
                bus.reg_write, bus.link_write, bus.pc_write, bus.pc_sel, bus.halted};
    endfunction

    task automatic randomize_inputs();
        bus.imem_ready  = 1'($urandom);
        bus.dmem_ready  = 1'($urandom);
        bus.take_branch = 1'($urandom);
        bus.stall_req   = 1'($urandom);
        bus.opclass     = 3'($urandom);
    endtask

    // Inputs are set by the caller just after a rising edge; outputs are
    // checked mid-cycle, then the task advances past the next rising edge.
    task automatic step(input string tag, input outs_t e);
        #2;
        check(tag, {19'b0, observed()}, {19'b0, e});
        check({tag, "_cnt"}, bus.instr_count, model_count);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input int op, input int iw, input int st, input int dw,
                             input bit tkn, input bit abort_mem);
        outs_t e;
        for (int i = 0; i <= iw; i++) begin
            randomize_inputs();
            bus.imem_ready = (i == iw);
            e = '0; e.state = 3'd1; e.imem_req = 1'b1; e.ir_write = (i == iw);
            step("fetch", e);
        end
        for (int i = 0; i <= st; i++) begin
            randomize_inputs();
            bus.stall_req = (i < st);
            if (i == st) bus.opclass = 3'(op);
            e = '0; e.state = 3'd2;
            step("decode", e);
        end
        randomize_inputs();
        bus.take_branch = tkn;
        e = '0; e.state = 3'd3;
        case (op)
            3: begin e.pc_write = 1'b1; e.pc_sel = tkn ? 2'd1 : 2'd0; end
            4: begin e.pc_write = 1'b1; e.pc_sel = 2'd2; end
            5: begin e.pc_write = 1'b1; e.pc_sel = 2'd2; e.link_write = 1'b1; end
            6: begin e.pc_write = 1'b1; e.pc_sel = 2'd3; end
            default: ;
        endcase
        step("exec", e);
        if (op >= 3) begin
            model_count++;
            return;
        end
        if (op == 1 || op == 2) begin
            for (int i = 0; i <= dw; i++) begin
                randomize_inputs();
                bus.dmem_ready = (i == dw);
                e = '0; e.state = 3'd4; e.dmem_req = 1'b1; e.dmem_we = (op == 2);
                e.pc_write = (op == 2) && (i == dw);
                if (abort_mem) begin
                    bus.dmem_ready = 1'b0;
                    e.pc_write = 1'b0;
                    #2;
                    check("mem_pre_reset", {19'b0, observed()}, {19'b0, e});
                    reset = 1'b1;
                    model_count = 0;
                    #1;
                    check("async_reset_outs", {19'b0, observed()}, 32'd0);
                    check("async_reset_cnt", bus.instr_count, model_count);
                    @(posedge clk);
                    #1;
                    check("held_reset_outs", {19'b0, observed()}, 32'd0);
                    reset = 1'b0;
                    randomize_inputs();
                    step("idle_after_reset", '0);
                    return;
                end
                step("mem", e);
            end
            if (op == 2) begin
                model_count++;
                return;
            end
        end
        randomize_inputs();
        e = '0; e.state = 3'd5; e.reg_write = 1'b1; e.pc_write = 1'b1;
        step("wb", e);
        model_count++;
    endtask

    initial begin
        outs_t e;
        reset = 1'b1;
        randomize_inputs();
        @(posedge clk);
        #1;
        check("reset_outs", {19'b0, observed()}, 32'd0);
        check("reset_cnt", bus.instr_count, 32'd0);
        reset = 1'b0;
        randomize_inputs();
        step("idle", '0);

        run_instr(0, 0, 0, 0, 1'b0, 1'b0);
        check("alu_retire_cnt", bus.instr_count, 32'd1);
        run_instr(1, 0, 0, 2, 1'b0, 1'b0);
        run_instr(3, 0, 0, 0, 1'b1, 1'b0);
        run_instr(3, 0, 0, 0, 1'b0, 1'b0);
        check("branch_pair_cnt", bus.instr_count, model_count);
        run_instr(5, 1, 0, 0, 1'b0, 1'b0);
        run_instr(6, 0, 0, 0, 1'b1, 1'b0);
        run_instr(2, 0, 3, 0, 1'b0, 1'b0);
        run_instr(2, 2, 0, 1, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            run_instr(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom), 1'b0);
            check("rand_cnt", bus.instr_count, model_count);
        end

        force dut.instr_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.instr_count_q;
        model_count = 32'hFFFF_FFFE;
        run_instr(0, 0, 0, 0, 1'b0, 1'b0);
        check("pre_wrap_cnt", bus.instr_count, 32'hFFFF_FFFF);
        run_instr(4, 0, 0, 0, 1'b0, 1'b0);
        check("wrap_cnt", bus.instr_count, 32'd0);

        run_instr(1, 0, 0, 3, 1'b0, 1'b1);
        run_instr(0, 0, 0, 0, 1'b0, 1'b0);
        check("post_reset_cnt", bus.instr_count, 32'd1);

        run_instr(7, 0, 1, 0, 1'b0, 1'b0);
        for (int n = 0; n < 20; n++) begin
            randomize_inputs();
            e = '0; e.state = 3'd6; e.halted = 1'b1;
            step("halt", e);
        end
        check("halt_frozen_cnt", bus.instr_count, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
